// File: rtl/laser_pkg.sv
// Shared types and constants for the multi-beam player laser bank.
// Holds the per-channel FSM encoding, playfield defaults and the x clamp helper.
package laser_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHARGE = 2'd1,
        ST_FIRE   = 2'd2,
        ST_COOL   = 2'd3
    } laser_state_e;

    localparam int MAX_X_DEF = 384;
    localparam int MAX_Y_DEF = 448;

    localparam logic [11:0] RGB_TRANSPARENT = 12'h000;

    // Beam rest position before the first tick has sampled player_y.
    localparam logic [9:0] RESET_BOT = 10'd399;

    function automatic logic [9:0] clamp_x(input int v, input int hi);
        if (v < 0) begin
            return 10'd0;
        end else if (v > hi) begin
            return 10'(hi);
        end else begin
            return 10'(v);
        end
    endfunction

endpackage

// File: rtl/laser_channel.sv
// One beam channel: charge/fire/cool FSM plus its x position and vertical extent.
// All state moves only on the game tick; the beam is empty (top == bot) outside FIRE.
module laser_channel
    import laser_pkg::*;
#(
    parameter int IDX          = 0,
    parameter int LASER_W      = 16,
    parameter int MAX_X        = MAX_X_DEF,
    parameter int SPACING      = 20,
    parameter int GROW_STEP    = 16,
    parameter int CHARGE_TICKS = 4,
    parameter int FIRE_TICKS   = 48,
    parameter int COOL_TICKS   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       shooting,
    input  logic [2:0] active_cnt,
    input  logic [9:0] player_x,
    input  logic [9:0] player_y,
    output logic [1:0] state_dbg,
    output logic       firing,
    output logic [9:0] beam_x,
    output logic [9:0] beam_top,
    output logic [9:0] beam_bot
);

    localparam int MAX_A     = (CHARGE_TICKS > FIRE_TICKS) ? CHARGE_TICKS : FIRE_TICKS;
    localparam int MAX_TICKS = (MAX_A > COOL_TICKS) ? MAX_A : COOL_TICKS;
    localparam int CNT_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

    laser_state_e      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [9:0]        beam_x_q, beam_x_d;
    logic [9:0]        top_q, top_d;
    logic [9:0]        bot_q, bot_d;
    logic              en;
    logic signed [11:0] off;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        beam_x_d = beam_x_q;
        top_d    = top_q;
        bot_d    = bot_q;
        en       = (IDX < int'(active_cnt));
        off      = 12'(IDX * SPACING - ((int'(active_cnt) - 1) * SPACING) / 2);

        if (tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (shooting) begin
                        state_d = ST_CHARGE;
                        cnt_d   = '0;
                    end
                end
                ST_CHARGE: begin
                    if (!shooting) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_W'(CHARGE_TICKS - 1)) begin
                        state_d = ST_FIRE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_FIRE: begin
                    if (!shooting || cnt_q == CNT_W'(FIRE_TICKS - 1)) begin
                        state_d = ST_COOL;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    if (cnt_q == CNT_W'(COOL_TICKS - 1)) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            endcase

            // A disabled channel is forced home regardless of its current phase.
            if (!en) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end

            bot_d    = (player_y == 10'd0) ? 10'd0 : player_y - 10'd1;
            beam_x_d = clamp_x(int'(player_x) - LASER_W / 2 + int'(off), MAX_X - LASER_W);

            // The beam only grows while it stays in FIRE; entering FIRE starts it empty.
            if (state_q == ST_FIRE && state_d == ST_FIRE) begin
                top_d = (int'(top_q) >= GROW_STEP) ? top_q - 10'(GROW_STEP) : 10'd0;
            end else begin
                top_d = bot_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            beam_x_q <= 10'(MAX_X / 2 - LASER_W / 2);
            top_q    <= RESET_BOT;
            bot_q    <= RESET_BOT;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            beam_x_q <= beam_x_d;
            top_q    <= top_d;
            bot_q    <= bot_d;
        end
    end

    assign state_dbg = state_q;
    assign firing    = (state_q == ST_FIRE);
    assign beam_x    = beam_x_q;
    assign beam_top  = top_q;
    assign beam_bot  = bot_q;

endmodule

// File: rtl/laser_bank.sv
// Multi-beam player laser: tick divider, texture scroll phase, N beam channels,
// and the priority pixel mux feeding the VGA path and collision geometry buses.
module laser_bank
    import laser_pkg::*;
#(
    parameter int N_LASERS     = 3,
    parameter int LASER_W      = 16,
    parameter int TEX_H        = 32,
    parameter int MAX_X        = MAX_X_DEF,
    parameter int MAX_Y        = MAX_Y_DEF,
    parameter int TICK_DIV     = 2000000,
    parameter int SPACING      = 20,
    parameter int GROW_STEP    = 16,
    parameter int CHARGE_TICKS = 4,
    parameter int FIRE_TICKS   = 48,
    parameter int COOL_TICKS   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [9:0]            x,
    input  logic [9:0]            y,
    input  logic [9:0]            player_x,
    input  logic [9:0]            player_y,
    input  logic                  shooting,
    input  logic [1:0]            level,
    output logic [12:0]           sprite_addr,
    input  logic [11:0]           sprite_rgb,
    output logic [11:0]           rgb_out,
    output logic                  laser_on,
    output logic [N_LASERS-1:0]   beam_active,
    output logic [10*N_LASERS-1:0] beam_x_flat,
    output logic [10*N_LASERS-1:0] beam_top_flat,
    output logic [10*N_LASERS-1:0] beam_bot_flat,
    output logic [2*N_LASERS-1:0] state_dbg_flat
);

    localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int PHASE_W = (TEX_H > 1) ? $clog2(TEX_H) : 1;

    logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
    logic               tick;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [2:0]         active_cnt;

    logic [N_LASERS-1:0] firing;
    logic [N_LASERS-1:0] hit;
    logic [9:0]          bx    [N_LASERS];
    logic [9:0]          top_a [N_LASERS];
    logic [9:0]          bot_a [N_LASERS];
    logic [1:0]          st_a  [N_LASERS];

    logic               hit_any;
    logic [9:0]         sel_x;
    logic [10:0]        y_sum;
    logic [PHASE_W-1:0] tex_row;

    always_comb begin
        active_cnt = 3'(level) + 3'd1;
        if (int'(active_cnt) > N_LASERS) begin
            active_cnt = 3'(N_LASERS);
        end
    end

    always_comb begin
        tick       = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        // TEX_H is a power of two, so the natural wrap gives the modulo.
        phase_d    = (tick && |firing) ? phase_q + 1'b1 : phase_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt_q <= '0;
            phase_q    <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            phase_q    <= phase_d;
        end
    end

    for (genvar i = 0; i < N_LASERS; i++) begin : g_ch
        laser_channel #(
            .IDX          (i),
            .LASER_W      (LASER_W),
            .MAX_X        (MAX_X),
            .SPACING      (SPACING),
            .GROW_STEP    (GROW_STEP),
            .CHARGE_TICKS (CHARGE_TICKS),
            .FIRE_TICKS   (FIRE_TICKS),
            .COOL_TICKS   (COOL_TICKS)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .tick       (tick),
            .shooting   (shooting),
            .active_cnt (active_cnt),
            .player_x   (player_x),
            .player_y   (player_y),
            .state_dbg  (st_a[i]),
            .firing     (firing[i]),
            .beam_x     (bx[i]),
            .beam_top   (top_a[i]),
            .beam_bot   (bot_a[i])
        );

        assign beam_x_flat[10*i +: 10]   = bx[i];
        assign beam_top_flat[10*i +: 10] = top_a[i];
        assign beam_bot_flat[10*i +: 10] = bot_a[i];
        assign state_dbg_flat[2*i +: 2]  = st_a[i];
    end

    assign beam_active = firing;

    always_comb begin
        hit = '0;
        for (int i = 0; i < N_LASERS; i++) begin
            hit[i] = firing[i]
                  && (x >= bx[i])
                  && ({1'b0, x} < ({1'b0, bx[i]} + 11'(LASER_W)))
                  && (y >= top_a[i])
                  && (y < bot_a[i])
                  && (int'(y) < MAX_Y);
        end
    end

    // Scan from the top index down so the lowest-index hit is the one left standing.
    always_comb begin
        hit_any = 1'b0;
        sel_x   = '0;
        y_sum   = 11'(y) + 11'(phase_q);
        tex_row = PHASE_W'(y_sum & 11'(TEX_H - 1));
        for (int i = N_LASERS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                hit_any = 1'b1;
                sel_x   = x - bx[i];
            end
        end
        sprite_addr = hit_any ? (13'(sel_x) + 13'(tex_row) * 13'(LASER_W)) : 13'd0;
        rgb_out     = hit_any ? sprite_rgb : 12'h000;
        laser_on    = hit_any && (sprite_rgb != RGB_TRANSPARENT);
    end

endmodule

// File: tb/tb_laser_bank.sv
// Directed bench for laser_bank with a fast tick (TICK_DIV=4) and a second,
// tightly spaced instance to exercise overlapping beams.
module tb_laser_bank;

  logic        clk;
  logic        reset;
  logic [9:0]  x, y, player_x, player_y;
  logic        shooting;
  logic [1:0]  level;
  logic [11:0] sprite_rgb;

  logic [12:0] sprite_addr, sprite_addr_ov;
  logic [11:0] rgb_out, rgb_out_ov;
  logic        laser_on, laser_on_ov;
  logic [2:0]  beam_active, beam_active_ov;
  logic [29:0] beam_x_flat, beam_top_flat, beam_bot_flat;
  logic [29:0] beam_x_flat_ov, beam_top_flat_ov, beam_bot_flat_ov;
  logic [5:0]  state_dbg_flat, state_dbg_flat_ov;

  int n_checks;
  int n_fail;
  logic [9:0] exp_q[$];

  laser_bank #(.N_LASERS(3), .TICK_DIV(4), .SPACING(20)) dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .player_x(player_x), .player_y(player_y),
    .shooting(shooting), .level(level), .sprite_addr(sprite_addr), .sprite_rgb(sprite_rgb),
    .rgb_out(rgb_out), .laser_on(laser_on), .beam_active(beam_active),
    .beam_x_flat(beam_x_flat), .beam_top_flat(beam_top_flat), .beam_bot_flat(beam_bot_flat),
    .state_dbg_flat(state_dbg_flat)
  );

  laser_bank #(.N_LASERS(3), .TICK_DIV(4), .SPACING(8)) dut_ov (
    .clk(clk), .reset(reset), .x(x), .y(y), .player_x(player_x), .player_y(player_y),
    .shooting(shooting), .level(level), .sprite_addr(sprite_addr_ov), .sprite_rgb(sprite_rgb),
    .rgb_out(rgb_out_ov), .laser_on(laser_on_ov), .beam_active(beam_active_ov),
    .beam_x_flat(beam_x_flat_ov), .beam_top_flat(beam_top_flat_ov), .beam_bot_flat(beam_bot_flat_ov),
    .state_dbg_flat(state_dbg_flat_ov)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // one game tick is four clocks; leaves us 1 time unit past the tick edge
  task automatic run_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      repeat (4) @(posedge clk);
      #1;
    end
  endtask

  task automatic probe(input logic [9:0] px, input logic [9:0] py, input logic [11:0] rgb);
    x = px;
    y = py;
    sprite_rgb = rgb;
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    reset = 1'b1;
    x = '0; y = '0;
    player_x = 10'd200; player_y = 10'd400;
    shooting = 1'b0; level = 2'd0; sprite_rgb = 12'h000;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // reset state
    check_eq("rst_active", beam_active, 3'b000);
    check_eq("rst_laser_on", laser_on, 1'b0);
    check_eq("rst_rgb", rgb_out, 12'h000);
    check_eq("rst_beam_x0", beam_x_flat[9:0], 10'd184);
    check_eq("rst_top0", beam_top_flat[9:0], 10'd399);
    check_eq("rst_bot0", beam_bot_flat[9:0], 10'd399);
    check_eq("rst_tick_cnt", dut.tick_cnt_q, 2'd0);
    check_eq("rst_state0", state_dbg_flat[1:0], 2'd0);

    // single channel: charge for four ticks then fire
    shooting = 1'b1;
    run_ticks(1);
    check_eq("t1_state0_charge", state_dbg_flat[1:0], 2'd1);
    check_eq("t1_beam_x0", beam_x_flat[9:0], 10'd192);
    check_eq("t1_bot0", beam_bot_flat[9:0], 10'd399);
    check_eq("t1_active", beam_active, 3'b000);
    run_ticks(3);
    check_eq("t4_state0_charge", state_dbg_flat[1:0], 2'd1);
    check_eq("t4_active", beam_active, 3'b000);

    exp_q.push_back(10'd399);
    exp_q.push_back(10'd383);
    exp_q.push_back(10'd367);
    exp_q.push_back(10'd351);
    for (int k = 0; k < 4; k++) begin
      run_ticks(1);
      check_eq("fire_active", beam_active, 3'b001);
      check_eq("fire_top0", beam_top_flat[9:0], exp_q.pop_front());
    end

    // tick 8: top=351 bot=399 beam_x=192 phase=3
    probe(10'd195, 10'd360, 12'hF0F);
    check_eq("pix_addr", sprite_addr, 13'd179);
    check_eq("pix_rgb", rgb_out, 12'hF0F);
    check_eq("pix_on", laser_on, 1'b1);
    probe(10'd195, 10'd360, 12'h000);
    check_eq("pix_transp_on", laser_on, 1'b0);
    check_eq("pix_transp_addr", sprite_addr, 13'd179);
    probe(10'd195, 10'd350, 12'hF0F);
    check_eq("pix_above_addr", sprite_addr, 13'd0);
    check_eq("pix_above_on", laser_on, 1'b0);
    check_eq("pix_above_rgb", rgb_out, 12'h000);
    probe(10'd195, 10'd399, 12'hF0F);
    check_eq("pix_bot_excl_on", laser_on, 1'b0);
    probe(10'd207, 10'd360, 12'hF0F);
    check_eq("pix_right_addr", sprite_addr, 13'd191);
    probe(10'd208, 10'd360, 12'hF0F);
    check_eq("pix_right_out_on", laser_on, 1'b0);
    probe(10'd191, 10'd360, 12'hF0F);
    check_eq("pix_left_out_on", laser_on, 1'b0);
    probe(10'd0, 10'd0, 12'h000);

    // growth saturates at 0
    run_ticks(21);
    check_eq("t29_top0", beam_top_flat[9:0], 10'd15);
    run_ticks(1);
    check_eq("t30_top0", beam_top_flat[9:0], 10'd0);
    run_ticks(1);
    check_eq("t31_top0", beam_top_flat[9:0], 10'd0);

    // held fire is cut after 48 ticks
    run_ticks(21);
    check_eq("t52_active", beam_active, 3'b001);
    run_ticks(1);
    check_eq("t53_active", beam_active, 3'b000);
    check_eq("t53_state0_cool", state_dbg_flat[1:0], 2'd3);
    check_eq("t53_top0", beam_top_flat[9:0], 10'd399);
    run_ticks(15);
    check_eq("t68_state0_cool", state_dbg_flat[1:0], 2'd3);
    run_ticks(1);
    check_eq("t69_state0_idle", state_dbg_flat[1:0], 2'd0);
    run_ticks(1);
    check_eq("t70_state0_charge", state_dbg_flat[1:0], 2'd1);
    run_ticks(3);
    check_eq("t73_active", beam_active, 3'b000);
    run_ticks(1);
    check_eq("t74_active", beam_active, 3'b001);

    // release at fire tick 10, press again during cool
    run_ticks(9);
    check_eq("t83_active", beam_active, 3'b001);
    shooting = 1'b0;
    run_ticks(1);
    check_eq("t84_active", beam_active, 3'b000);
    check_eq("t84_state0_cool", state_dbg_flat[1:0], 2'd3);
    run_ticks(2);
    shooting = 1'b1;
    run_ticks(13);
    check_eq("t99_state0_cool", state_dbg_flat[1:0], 2'd3);
    run_ticks(1);
    check_eq("t100_state0_idle", state_dbg_flat[1:0], 2'd0);
    run_ticks(1);
    check_eq("t101_state0_charge", state_dbg_flat[1:0], 2'd1);
    run_ticks(4);
    check_eq("t105_active", beam_active, 3'b001);
    run_ticks(1);

    // reset in the middle of FIRE
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_eq("midrst_active", beam_active, 3'b000);
    check_eq("midrst_state0", state_dbg_flat[1:0], 2'd0);
    check_eq("midrst_top0", beam_top_flat[9:0], 10'd399);
    check_eq("midrst_bot0", beam_bot_flat[9:0], 10'd399);
    check_eq("midrst_tick_cnt", dut.tick_cnt_q, 2'd0);

    // three channels spread around the ship
    level = 2'd2;
    run_ticks(1);
    check_eq("lv2_state_all", state_dbg_flat, 6'b01_01_01);
    check_eq("lv2_bx0", beam_x_flat[9:0], 10'd172);
    check_eq("lv2_bx1", beam_x_flat[19:10], 10'd192);
    check_eq("lv2_bx2", beam_x_flat[29:20], 10'd212);
    check_eq("ov_bx0", beam_x_flat_ov[9:0], 10'd184);
    check_eq("ov_bx1", beam_x_flat_ov[19:10], 10'd192);
    check_eq("ov_bx2", beam_x_flat_ov[29:20], 10'd200);
    run_ticks(4);
    check_eq("lv2_active", beam_active, 3'b111);
    check_eq("ov_active", beam_active_ov, 3'b111);
    run_ticks(2);

    // phase=2, tops=367: overlap pixel resolves to channel 0
    probe(10'd195, 10'd380, 12'hF0F);
    check_eq("ov_pix_addr", sprite_addr_ov, 13'd491);
    check_eq("ov_pix_on", laser_on_ov, 1'b1);
    check_eq("lv2_pix_addr", sprite_addr, 13'd483);
    probe(10'd0, 10'd0, 12'h000);

    // x clamping at both playfield edges
    player_x = 10'd5;
    run_ticks(1);
    check_eq("clamp_lo_bx0", beam_x_flat[9:0], 10'd0);
    check_eq("clamp_lo_bx1", beam_x_flat[19:10], 10'd0);
    check_eq("clamp_lo_bx2", beam_x_flat[29:20], 10'd17);
    player_x = 10'd380;
    run_ticks(1);
    check_eq("clamp_hi_bx0", beam_x_flat[9:0], 10'd352);
    check_eq("clamp_hi_bx1", beam_x_flat[19:10], 10'd368);
    check_eq("clamp_hi_bx2", beam_x_flat[29:20], 10'd368);

    // bottom saturates at 0
    player_y = 10'd0;
    run_ticks(1);
    check_eq("bot_sat0", beam_bot_flat[9:0], 10'd0);

    // dropping the level sends the upper channels home
    level = 2'd0;
    run_ticks(1);
    check_eq("lv0_active", beam_active, 3'b001);
    check_eq("lv0_state12", state_dbg_flat[5:2], 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
